// File: rtl/wb_mem_pkg.sv
// wb_mem_pkg: shared constants and FSM state type for the Wishbone memory responder
package wb_mem_pkg;
    localparam logic [29:0] EXIT_ADR_DEFAULT  = 30'h0400_0001;
    localparam logic [31:0] EXIT_CODE_DEFAULT = 32'h0000_00AD;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_resp_state_t;
endpackage

// File: rtl/wb_mem_bank.sv
// wb_mem_bank: single-port block RAM with byte-lane write enables and a registered read
module wb_mem_bank #(
    parameter int WORDS = 65536,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rd,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and a read register that only moves on reads, so it holds the last read word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (rd) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone-style RAM responder with exit port, error flag and run-cycle counter
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 65536,
    parameter int          WAIT_STATES = 0,
    parameter logic [29:0] EXIT_ADR    = EXIT_ADR_DEFAULT,
    parameter logic [31:0] EXIT_CODE   = EXIT_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] adr,
    input  logic [31:0] dat,
    input  logic [3:0]  sel,
    input  logic        we,
    input  logic        cyc,
    output logic [31:0] rdt,
    output logic        ack,
    output logic        done,
    output logic        err,
    output logic [31:0] cycle_count
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    wb_resp_state_t state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ram_src_q, ram_src_d;
    logic [31:0] rdt_q, rdt_d;
    logic [31:0] count_q, count_d;
    logic        accept, commit, hit_exit, hit_ram, exit_match;
    logic [31:0] ram_rdata;

    // Decode of the latched request; the access commits on the edge that leaves ACK
    always_comb begin
        accept     = (state_q == IDLE) && cyc && !ack_q;
        commit     = state_q == ACK;
        hit_exit   = adr_q == EXIT_ADR;
        hit_ram    = !hit_exit && ({2'b00, adr_q} < 32'(MEM_WORDS));
        exit_match = we_q && (sel_q == 4'hF) && (dat_q == EXIT_CODE);
    end

    wb_mem_bank #(.WORDS(MEM_WORDS), .AW(AW)) u_bank (
        .clk   (clk),
        .rd    (commit && hit_ram && !we_q),
        .wen   ({4{commit && hit_ram && we_q}} & sel_q),
        .addr  (adr_q[AW-1:0]),
        .wdata (dat_q),
        .rdata (ram_rdata)
    );

    // Next state, request latch, sticky flags, non-RAM read data and the saturating run counter
    always_comb begin
        state_d   = accept ? ((WAIT_STATES == 0) ? ACK : WAIT)
                  : (state_q == WAIT) ? ((wait_q == 4'd1) ? ACK : WAIT)
                  : (state_q == ACK) ? IDLE : state_q;
        wait_d    = accept ? 4'(WAIT_STATES) : (state_q == WAIT) ? wait_q - 4'd1 : wait_q;
        adr_d     = accept ? adr : adr_q;
        dat_d     = accept ? dat : dat_q;
        sel_d     = accept ? sel : sel_q;
        we_d      = accept ? we : we_q;
        ack_d     = commit;
        done_d    = done_q | (commit && hit_exit && exit_match);
        err_d     = err_q | (commit && !hit_exit && !hit_ram);
        ram_src_d = (commit && !we_q) ? hit_ram : ram_src_q;
        rdt_d     = (commit && !we_q) ? (hit_exit ? {31'b0, done_q} : 32'h0) : rdt_q;
        count_d   = (done_q || (&count_q)) ? count_q : count_q + 32'd1;
    end

    // State and output registers; the RAM itself is never reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ram_src_q <= 1'b0;
            rdt_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ram_src_q <= ram_src_d;
            rdt_q     <= rdt_d;
            count_q   <= count_d;
        end
    end

    assign rdt         = ram_src_q ? ram_rdata : rdt_q;
    assign ack         = ack_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cycle_count = count_q;
endmodule
